tft_spi_receiver: RTL

- Display-side receiver for the 4-wire TFT SPI bus (clk, mosi, dc, cs) driven by the team's SPI transmitter.
- Oversamples the bus on the system clock and deserialises bytes MSB-first.
- Decodes the ILI9341-style window/pixel command subset (CASET 0x2A, PASET 0x2B, RAMWR 0x2C) into per-pixel writes with x/y coordinates.
- Hangs off the analyzer outputs in the bench and on hardware, so the init and scene streams can be checked pixel by pixel.

---
 rtl/tft_spi_receiver.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tft_spi_receiver.sv
// ---------------------------------------------------------------------------
// tft_spi_receiver
//
// Receiver for the 4-wire TFT SPI bus. It samples the bus on the system clock
// and shifts in bytes MSB first on the rising edge of spi_clk (SPI mode 0).
// It also decodes the ILI9341 window and pixel commands into per-pixel writes:
//   CASET 0x2A : column window (4 argument bytes: start hi/lo, end hi/lo)
//   PASET 0x2B : row window    (same argument layout)
//   RAMWR 0x2C : pixel stream, 2 bytes per pixel, {hi, lo} RGB565
//
// Ports
//   clk, rst          system clock, synchronous active-low reset
//   spi_clk/mosi/dc/cs  bus inputs, asynchronous to clk
//   byte_valid/data/dc  one-cycle strobe plus the last received byte and its dc
//   pix_valid/x/y/color one-cycle strobe plus the pixel write
//   frame_done          strobe together with the last pixel of the window
//   cmd_err             strobe when CASET/PASET arguments are rejected
//
// Optional build macro
//   TFT_RX_CS_EN : when defined, spi_cs is honoured. While cs is high, the bit
//                  counter is cleared and sampling is held off. When it is
//                  undefined, spi_cs is ignored because the board ties cs low.
//
// Each spi_clk phase must last at least 3 clk periods.
// ---------------------------------------------------------------------------
module tft_spi_receiver #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int COORD_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_clk,
    input  logic               spi_mosi,
    input  logic               spi_dc,
    input  logic               spi_cs,
    output logic               byte_valid,
    output logic [7:0]         byte_data,
    output logic               byte_dc,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_color,
    output logic               frame_done,
    output logic               cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        CASET_ARG,
        PASET_ARG,
        RAMWR_HI,
        RAMWR_LO
    } state_t;

    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] dc_sync;
    logic       sclk_prev;
    logic       selected;
    logic       sample_edge;

    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;

`ifdef TFT_RX_CS_EN
    logic [1:0] cs_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_sync <= 2'b11;
        end else begin
            cs_sync <= {cs_sync[0], spi_cs};
        end
    end

    assign selected = ~cs_sync[1];
`else
    logic unused_cs;

    assign unused_cs = spi_cs;
    assign selected  = 1'b1;
`endif

    // spi_clk and mosi go through synchronisers of the same depth, so the
    // mosi sample taken at a synced clk edge lines up with the pin timing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            dc_sync   <= {dc_sync[0], spi_dc};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign sample_edge = sclk_sync[1] & ~sclk_prev & selected;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            byte_data  <= 8'h00;
            byte_dc    <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (!selected) begin
                bit_cnt <= 3'd0;
            end else if (sample_edge) begin
                shift_reg <= {shift_reg[6:0], mosi_sync[1]};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_data  <= {shift_reg[6:0], mosi_sync[1]};
                    byte_dc    <= dc_sync[1];
                    byte_valid <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command decoder
    // ------------------------------------------------------------------
    state_t             state, state_n;
    logic [1:0]         arg_idx, arg_idx_n;
    logic [7:0]         arg0, arg0_n;
    logic [7:0]         arg1, arg1_n;
    logic [7:0]         arg2, arg2_n;
    logic [7:0]         hi_byte, hi_byte_n;
    logic [COORD_W-1:0] cur_x, cur_x_n;
    logic [COORD_W-1:0] cur_y, cur_y_n;
    logic [COORD_W-1:0] xs, xs_n, xe, xe_n;
    logic [COORD_W-1:0] ys, ys_n, ye, ye_n;
    logic               pix_fire, frame_fire, err_fire;

    logic [15:0]        arg_start, arg_end, arg_limit;
    logic               arg_bad;

    // The comparison uses all 16 bits. This means an end value with high bits
    // set beyond COORD_W fails the range test and does not wrap into range.
    assign arg_start = {arg0, arg1};
    assign arg_end   = {arg2, byte_data};
    assign arg_limit = (state == CASET_ARG) ? 16'(WIDTH) : 16'(HEIGHT);
    assign arg_bad   = (arg_start > arg_end) || (arg_end >= arg_limit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            arg_idx    <= 2'd0;
            arg0       <= 8'h00;
            arg1       <= 8'h00;
            arg2       <= 8'h00;
            hi_byte    <= 8'h00;
            cur_x      <= '0;
            cur_y      <= '0;
            xs         <= '0;
            xe         <= COORD_W'(WIDTH - 1);
            ys         <= '0;
            ye         <= COORD_W'(HEIGHT - 1);
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_color  <= 16'h0000;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_n;
            arg_idx    <= arg_idx_n;
            arg0       <= arg0_n;
            arg1       <= arg1_n;
            arg2       <= arg2_n;
            hi_byte    <= hi_byte_n;
            cur_x      <= cur_x_n;
            cur_y      <= cur_y_n;
            xs         <= xs_n;
            xe         <= xe_n;
            ys         <= ys_n;
            ye         <= ye_n;
            pix_valid  <= pix_fire;
            frame_done <= frame_fire;
            cmd_err    <= err_fire;
            if (pix_fire) begin
                pix_x     <= cur_x;
                pix_y     <= cur_y;
                pix_color <= {hi_byte, byte_data};
            end
        end
    end

    // A command byte always wins over the current state. Any partial argument
    // set or unpaired high byte is dropped when the state is left.
    always_comb begin
        state_n    = state;
        arg_idx_n  = arg_idx;
        arg0_n     = arg0;
        arg1_n     = arg1;
        arg2_n     = arg2;
        hi_byte_n  = hi_byte;
        cur_x_n    = cur_x;
        cur_y_n    = cur_y;
        xs_n       = xs;
        xe_n       = xe;
        ys_n       = ys;
        ye_n       = ye;
        pix_fire   = 1'b0;
        frame_fire = 1'b0;
        err_fire   = 1'b0;

        if (byte_valid) begin
            if (!byte_dc) begin
                arg_idx_n = 2'd0;
                case (byte_data)
                    8'h2A:   state_n = CASET_ARG;
                    8'h2B:   state_n = PASET_ARG;
                    8'h2C: begin
                        state_n = RAMWR_HI;
                        cur_x_n = xs;
                        cur_y_n = ys;
                    end
                    default: state_n = IDLE;
                endcase
            end else begin
                case (state)
                    CASET_ARG, PASET_ARG: begin
                        arg_idx_n = arg_idx + 2'd1;
                        case (arg_idx)
                            2'd0: arg0_n = byte_data;
                            2'd1: arg1_n = byte_data;
                            2'd2: arg2_n = byte_data;
                            default: begin
                                state_n = IDLE;
                                if (arg_bad) begin
                                    err_fire = 1'b1;
                                end else if (state == CASET_ARG) begin
                                    xs_n = arg_start[COORD_W-1:0];
                                    xe_n = arg_end[COORD_W-1:0];
                                end else begin
                                    ys_n = arg_start[COORD_W-1:0];
                                    ye_n = arg_end[COORD_W-1:0];
                                end
                            end
                        endcase
                    end
                    RAMWR_HI: begin
                        hi_byte_n = byte_data;
                        state_n   = RAMWR_LO;
                    end
                    RAMWR_LO: begin
                        pix_fire = 1'b1;
                        state_n  = RAMWR_HI;
                        if (cur_x != xe) begin
                            cur_x_n = cur_x + COORD_W'(1);
                        end else if (cur_y != ye) begin
                            cur_x_n = xs;
                            cur_y_n = cur_y + COORD_W'(1);
                        end else begin
                            frame_fire = 1'b1;
                            cur_x_n    = xs;
                            cur_y_n    = ys;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
